instr_prefetch_ir: RTL
======================

Name: instr_prefetch_ir

Overview:
- Parametrised successor to the CPU's single instruction register.
- A DEPTH-entry prefetch queue accepts instruction words from the fetch path.
- An output instruction register loads from the queue head on IRload and flags stalls.
- Provides a half-word view for packed short instructions, selected by shadow.
- Sits between memory data-out and the controller/decoder.

Parameters:
WIDTH, 16, instruction word width; must be even and ≥4
DEPTH, 4, queue entries; power of two, ≥2
PTR_W, 2, log2(DEPTH); set consistently with DEPTH

Ports:
clk  input  1  system clock; all state updates on the falling edge, matching CPU register timing
rst  input  1  synchronous active-high reset, sampled on the falling edge of clk
flush  input  1  discard queued words (branch/jump taken)
wr_valid  input  1  fetch path presents wr_data
wr_data  input  WIDTH  instruction word from memory
wr_ready  output  1  queue can accept; equals ~full
IRload  input  1  load the queue head into the instruction register
shadow  input  1  half select: 0 = upper half, 1 = lower half
ir_out  output  WIDTH  instruction register contents
ir_valid  output  1  ir_out holds a word loaded on the last IRload edge
ir_half  output  WIDTH/2  selected half of ir_out
count  output  PTR_W+1  words currently queued, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH

Behaviour:
Edge and reset
- All registers update on the negedge of clk.
- Priority on each edge: rst > flush > normal operation.
- Reset values: ir_out=0, ir_valid=0, count=0, read/write pointers=0.
- Resulting outputs after reset: empty=1, full=0, wr_ready=1, ir_half=0.
- Reset mid-stream discards all queued words.

Push
- Occurs when wr_valid & wr_ready: the word is written at wr_ptr and wr_ptr advances modulo DEPTH.
- wr_valid while full: no write; the word must be held by the source.

Pop / IR load
- When IRload & ~empty: ir_out <= entry at rd_ptr, rd_ptr advances modulo DEPTH, ir_valid <= 1.
- When IRload & empty: ir_out holds its previous value, ir_valid <= 0 (stall).
- No bypass: a word pushed on the same edge is not loaded.
- When IRload=0: ir_out and ir_valid hold.

Count
- Push only: count+1.
- Pop only: count-1.
- Push and pop on the same edge: count unchanged.
- Possible when 0<count<DEPTH, and also when count==0 and full is clear — but at count==0 no pop occurs, so that case is push only.

Flush
- Pointers and count return to 0; ir_valid <= 0; ir_out holds.
- Any push or IRload on the flush edge is ignored.

Combinational outputs
- empty, full and wr_ready are decoded from the count register.
- ir_half = shadow ? ir_out[WIDTH/2-1:0] : ir_out[WIDTH-1:WIDTH/2]. It changes immediately with shadow and does not require an edge.

Latency
- A word pushed at edge n is loadable at edge n+1 at the earliest.
- Words leave the queue in strict FIFO order across pointer wrap-around.

Test Plan:
- Reset, then push 0x1234 and 0xABCD on consecutive edges, then IRload on two edges -> ir_out=0x1234 then 0xABCD, ir_valid=1, count 2→1→0, empty=1.
- Push 4 words (0x0001..0x0004) with no IRload -> full=1, wr_ready=0, count=4; a 5th push of 0x0005 is dropped; 4 loads return 0x0001..0x0004.
- Wrap-around: push/pop continuously for 10 words (0x0010..0x0019) with count oscillating 1..3 -> loaded in exact order, pointers wrap, count never exceeds 4.
- IRload with empty queue after ir_out=0x5A5A -> ir_out stays 0x5A5A, ir_valid=0; simultaneous push of 0x7777 -> count=1, loaded only on the next IRload.
- Flush with count=3 plus a simultaneous push and IRload -> count=0, empty=1, ir_valid=0, ir_out unchanged; rst asserted together with flush -> ir_out=0.
- ir_out=0xC3A5: shadow=0 -> ir_half=0xC3; shadow=1 -> ir_half=0xA5, with no clock edge between the two checks.

Source files
------------

// File: rtl/instr_prefetch_ir.sv
// Prefetch queue in front of the instruction register.
// Words enter a DEPTH-entry FIFO; IRload moves the head into ir_out. All state updates on the falling clock edge.
module instr_prefetch_ir #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_valid,
    input  logic [WIDTH-1:0]   wr_data,
    output logic               wr_ready,
    input  logic               IRload,
    input  logic               shadow,
    output logic [WIDTH-1:0]   ir_out,
    output logic               ir_valid,
    output logic [WIDTH/2-1:0] ir_half,
    output logic [PTR_W:0]     count,
    output logic               empty,
    output logic               full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [WIDTH-1:0] r_ir;
    logic             r_ir_valid;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_push  = wr_valid & ~w_full;
    // Pop sees the pre-edge count, so a word pushed on this edge is never loaded.
    assign w_pop   = IRload & ~w_empty;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ir_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (IRload) begin
                r_ir_valid <= w_pop;
                if (w_pop) begin
                    r_ir     <= r_mem[r_rd_ptr];
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign wr_ready = ~w_full;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign ir_out   = r_ir;
    assign ir_valid = r_ir_valid;
    assign ir_half  = shadow ? r_ir[WIDTH/2-1:0] : r_ir[WIDTH-1:WIDTH/2];

endmodule
